// File: rtl/alu_pkg.sv
// Shared types and widths for the nibble-serial ALU.
// Optional feature macro used by this slice: NIBBLE_LOOP_EARLY_TERM_EN.
package alu_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned NUM_NIBBLES = WORD_W / NIBBLE_W;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } AluOp;

  typedef struct packed {
    AluOp op;
    logic carry_in;
  } AluCtrl;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nibble_state_t;

  // Replace word2 nibbles above 'last' with the sign fill.
  function automatic logic [WORD_W-1:0] effective_word2(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  last,
    input logic              neg
  );
    logic [WORD_W-1:0] r;
    r = w;
    for (int unsigned i = 0; i < NUM_NIBBLES; i++) begin
      if (i > {29'd0, last}) begin
        r[i*NIBBLE_W +: NIBBLE_W] = {NIBBLE_W{neg}};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_alu.sv
// Combinational 4-bit datapath: one nibble of ADD/SUB/AND/OR/XOR.
// SUB expects d2 already inverted and carry_in forced to 1 by the caller.
module nibble_alu
  import alu_pkg::*;
(
  input  AluOp                op,
  input  logic [NIBBLE_W-1:0] d1,
  input  logic [NIBBLE_W-1:0] d2,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  logic [NIBBLE_W:0] add_full;

  assign add_full = {1'b0, d1} + {1'b0, d2} + {{NIBBLE_W{1'b0}}, carry_in};

  // Select the nibble result; logic ops never propagate a carry.
  always_comb begin
    sum       = '0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        sum       = add_full[NIBBLE_W-1:0];
        carry_out = add_full[NIBBLE_W];
      end
      ALU_AND: sum = d1 & d2;
      ALU_OR:  sum = d1 | d2;
      ALU_XOR: sum = d1 ^ d2;
      default: begin
        sum       = '0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial ALU sequencer: IDLE -> RUN (one nibble per clock) -> DONE.
// Define NIBBLE_LOOP_EARLY_TERM_EN to let ADD stop once the remaining
// upper nibbles cannot change.
module loop_over_all_nibbles
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loop_perm_to_count,
  input  AluCtrl            ctrl,
  input  logic [IDX_W-1:0]  loop_nibbles_number,
  input  logic              word2_is_negative,
  input  logic [WORD_W-1:0] word1,
  input  logic [WORD_W-1:0] word2,
  input  logic [WORD_W-1:0] preinit_result,
  output logic [WORD_W-1:0] result,
  output logic              busy
);

  nibble_state_t       state;
  logic [IDX_W-1:0]    curr_nibble_idx;
  logic                result_carry;
  logic [WORD_W-1:0]   w1_q;
  logic [WORD_W-1:0]   w2_q;
  AluOp                op_q;

  logic [IDX_W+1:0]    bit_base;
  logic [NIBBLE_W-1:0] d1;
  logic [NIBBLE_W-1:0] w2_nib;
  logic [NIBBLE_W-1:0] d2;
  logic [NIBBLE_W-1:0] alu_sum;
  logic                alu_cout;
  logic                early_done;
  logic                last_nibble;

  assign bit_base = {curr_nibble_idx, 2'b00};
  assign d1       = w1_q[bit_base +: NIBBLE_W];
  assign w2_nib   = w2_q[bit_base +: NIBBLE_W];
  assign d2       = (op_q == ALU_SUB) ? ~w2_nib : w2_nib;

  nibble_alu u_nibble_alu (
    .op        (op_q),
    .d1        (d1),
    .d2        (d2),
    .carry_in  (result_carry),
    .sum       (alu_sum),
    .carry_out (alu_cout)
  );

`ifdef NIBBLE_LOOP_EARLY_TERM_EN
  logic [IDX_W-1:0] last_q;
  logic             neg_q;

  // Hold the loop bound and sign used by the early-exit test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      neg_q  <= 1'b0;
    end else if (state == IDLE && loop_perm_to_count) begin
      last_q <= loop_nibbles_number;
      neg_q  <= word2_is_negative;
    end
  end

  // Upper nibbles of an unsigned-extended ADD with no carry equal word1,
  // which the caller preloads through preinit_result.
  assign early_done = (op_q == ALU_ADD) && (curr_nibble_idx >= last_q) &&
                      !alu_cout && !neg_q;
`else
  assign early_done = 1'b0;
`endif

  assign last_nibble = (curr_nibble_idx == IDX_W'(NUM_NIBBLES - 1)) || early_done;

  // busy is combinational so the caller sees it in the request cycle.
  assign busy = rst_n && ((state == RUN) ||
                          (state == IDLE && loop_perm_to_count));

  // Sequencer and result/operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      result          <= '0;
      curr_nibble_idx <= '0;
      result_carry    <= 1'b0;
      w1_q            <= '0;
      w2_q            <= '0;
      op_q            <= ALU_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (loop_perm_to_count) begin
            result          <= preinit_result;
            w1_q            <= word1;
            w2_q            <= effective_word2(word2, loop_nibbles_number,
                                               word2_is_negative);
            op_q            <= ctrl.op;
            curr_nibble_idx <= '0;
            result_carry    <= (ctrl.op == ALU_SUB) ? 1'b1 : ctrl.carry_in;
            state           <= RUN;
          end
        end
        RUN: begin
          result[bit_base +: NIBBLE_W] <= alu_sum;
          result_carry                 <= alu_cout;
          if (last_nibble) begin
            state <= DONE;
          end else begin
            curr_nibble_idx <= curr_nibble_idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Bench for loop_over_all_nibbles: vector table + scoreboard queue,
// plus hand sequences for busy length, request held through DONE and reset.
module tb_loop_over_all_nibbles;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        loop_perm_to_count;
  AluCtrl      ctrl;
  logic [2:0]  loop_nibbles_number;
  logic        word2_is_negative;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] preinit_result;
  logic [31:0] result;
  logic        busy;

  int unsigned tests;
  int unsigned errors;
  logic [31:0] sb_q[$];

  typedef struct {
    AluOp        op;
    logic        cin;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [2:0]  n;
    logic        neg;
    logic [31:0] pre;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  loop_over_all_nibbles dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .loop_perm_to_count  (loop_perm_to_count),
    .ctrl                (ctrl),
    .loop_nibbles_number (loop_nibbles_number),
    .word2_is_negative   (word2_is_negative),
    .word1               (word1),
    .word2               (word2),
    .preinit_result      (preinit_result),
    .result              (result),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one operation, count RUN cycles, leave the bench in DONE->IDLE.
  task automatic run_op(input vec_t v, input bit hold_in_done,
                        output int unsigned cycles);
    logic [31:0] exp_r;
    bit          done;
    cycles = 0;
    done   = 0;
    @(negedge clk);
    ctrl.op             = v.op;
    ctrl.carry_in       = v.cin;
    word1               = v.w1;
    word2               = v.w2;
    loop_nibbles_number = v.n;
    word2_is_negative   = v.neg;
    preinit_result      = v.pre;
    loop_perm_to_count  = 1'b1;
    sb_q.push_back(v.exp);
    #1;
    check("busy_on_request", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) cycles++;
      else done = 1;
    end
    if (!done) check("busy_timeout", 32'd1, 32'd0);
    // Now in DONE: busy low, inputs changed to prove operands were captured.
    word1 = ~v.w1;
    word2 = ~v.w2;
    if (!hold_in_done) loop_perm_to_count = 1'b0;
    @(posedge clk);
    #1;
    loop_perm_to_count = 1'b0;
    @(negedge clk);
    exp_r = sb_q.pop_front();
    check("result", result, exp_r);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    logic [31:0] held;
    bit          saw_busy;
    tests  = 0;
    errors = 0;

    vecs[0]  = '{ALU_ADD, 1'b0, 32'h0000_00FF, 32'h0000_0004, 3'd0, 1'b0, 32'h0000_00FF, 32'h0000_0103};
    vecs[1]  = '{ALU_ADD, 1'b0, 32'h0000_0000, 32'h0000_007B, 3'd2, 1'b0, 32'h0000_0000, 32'h0000_007B};
    vecs[2]  = '{ALU_ADD, 1'b0, 32'h0000_0005, 32'h0000_0FFE, 3'd2, 1'b1, 32'h0000_0005, 32'h0000_0003};
    vecs[3]  = '{ALU_SUB, 1'b0, 32'h0000_000A, 32'h0000_0003, 3'd7, 1'b0, 32'h0000_0000, 32'h0000_0007};
    vecs[4]  = '{ALU_SUB, 1'b0, 32'h0000_0000, 32'h0000_0001, 3'd7, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5]  = '{ALU_XOR, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 3'd7, 1'b0, 32'h0000_0000, 32'h0F0F_0F0F};
    vecs[6]  = '{ALU_AND, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'h0204_0608};
    vecs[7]  = '{ALU_OR,  1'b0, 32'h1234_5678, 32'h0000_00A5, 3'd1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFD};
    vecs[8]  = '{ALU_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{ALU_ADD, 1'b0, 32'h0000_0001, 32'h0000_0002, 3'd7, 1'b1, 32'h0000_0001, 32'h0000_0003};
    vecs[10] = '{ALU_XOR, 1'b0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 3'd3, 1'b0, 32'h0000_0000, 32'hAAAA_5555};

    rst_n               = 1'b0;
    loop_perm_to_count  = 1'b0;
    ctrl.op             = ALU_ADD;
    ctrl.carry_in       = 1'b0;
    loop_nibbles_number = '0;
    word2_is_negative   = 1'b0;
    word1               = '0;
    word2               = '0;
    preinit_result      = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    loop_perm_to_count = 1'b1;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_idx", {29'd0, dut.curr_nibble_idx}, 32'd0);
    loop_perm_to_count = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], 1'b0, cyc);
`ifdef NIBBLE_LOOP_EARLY_TERM_EN
      if (vecs[i].op != ALU_ADD) check("run_cycles", cyc, 32'd8);
`else
      check("run_cycles", cyc, 32'd8);
`endif
    end

    // Carry chain through nibble 2 bounds the early exit.
    run_op(vecs[0], 1'b0, cyc);
`ifdef NIBBLE_LOOP_EARLY_TERM_EN
    check("busy_len_ff_plus_4", cyc, 32'd3);
`else
    check("busy_len_ff_plus_4", cyc, 32'd8);
`endif

    // Request held through DONE: exactly one operation, result holds.
    run_op(vecs[3], 1'b1, cyc);
    held     = result;
    saw_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("no_restart_after_done", {31'd0, saw_busy}, 32'd0);
    check("result_holds", result, held);

    // Reset mid-RUN aborts the operation.
    @(negedge clk);
    ctrl.op             = ALU_SUB;
    ctrl.carry_in       = 1'b0;
    word1               = 32'h0000_0000;
    word2               = 32'h0000_0001;
    loop_nibbles_number = 3'd7;
    word2_is_negative   = 1'b0;
    preinit_result      = 32'h5555_5555;
    loop_perm_to_count  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_result", result, 32'h0);
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check("midrun_reset_state", {30'd0, dut.state}, {30'd0, IDLE});
    check("midrun_reset_idx", {29'd0, dut.curr_nibble_idx}, 32'd0);
    check("midrun_reset_carry", {31'd0, dut.result_carry}, 32'd0);
    loop_perm_to_count = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    // Operation after reset recovers normally.
    run_op(vecs[4], 1'b0, cyc);

    if (sb_q.size() != 0) check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/loop_over_all_nibbles.md
LOOP_OVER_ALL_NIBBLES -- requirements
Module: loop_over_all_nibbles

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 loop_perm_to_count  input  1  operation request; held high by the caller until busy falls.
REQ-005 ctrl  input  AluCtrl  operation select: ADD/SUB/AND/OR/XOR, plus carry_in.
REQ-006 loop_nibbles_number  input  3  index of the last significant word2 nibble (0..7).
REQ-007 word2_is_negative  input  1  word2 nibbles above loop_nibbles_number are filled with 0xF (else 0x0).
REQ-008 word1, word2  input  32 each  operands; sampled at start and held internally.
REQ-009 preinit_result  input  32  initial content of result at start.
REQ-010 result  output  32  result register.
REQ-011 busy  output  1  operation pending/running.

Function
REQ-012 SHALL have states IDLE, RUN and DONE.
REQ-013 Start: in IDLE, with loop_perm_to_count=1 at a clock edge:
  - result<=preinit_result
  - capture operands
  - nibble index<=0
  - carry<=ctrl.carry_in (forced to 1 for SUB)
  - go to RUN.
REQ-014 busy SHALL be combinational: 1 in RUN, 1 in IDLE while loop_perm_to_count=1, 0 in DONE.
REQ-015 RUN SHALL process one nibble per clock, starting at nibble 0:
  - d1=word1 nibble, d2=effective word2 nibble (inverted for SUB)
  - result nibble<=op(d1,d2,carry)
  - carry<=adder carry-out for ADD/SUB, 0 for logic ops.
REQ-016 Effective word2 nibble i SHALL be word2[4i+:4] for i<=loop_nibbles_number, otherwise the sign fill defined in REQ-007.
REQ-017 RUN SHALL end after nibble 7, or earlier as defined in REQ-024; the next state is DONE.
REQ-018 DONE SHALL last exactly one cycle, ignore loop_perm_to_count, and then return to IDLE; result SHALL hold its value until the next start.
REQ-019 Carry out of nibble 7 SHALL be discarded, so addition wraps modulo 2^32.
REQ-020 loop_nibbles_number=7 SHALL use all of word2 and ignore word2_is_negative.

Reset
REQ-021 Asserting rst_n low SHALL immediately force:
  - state IDLE, result=0, nibble index=0, carry=0
  - busy=0 while rst_n is low.
REQ-022 Reset during RUN SHALL abort the operation; the caller must re-request it.

Configuration
REQ-023 Macro NIBBLE_LOOP_EARLY_TERM_EN selects the early-termination feature.
REQ-024 With the macro defined, ADD SHALL leave RUN after the last processed nibble i when all of the following hold:
  - i>=loop_nibbles_number
  - carry-out=0
  - word2_is_negative=0
  Upper result nibbles then keep their preinit_result value; the caller supplies preinit_result=word1 where that matters.
REQ-025 Without the macro, every operation SHALL process all 8 nibbles.

Structure
REQ-026 Package alu_pkg SHALL hold the AluOp enum, the AluCtrl struct (op, carry_in) and the nibble/word width constants.
REQ-027 Sub-module nibble_alu SHALL hold the combinational 4-bit datapath (d1, d2, carry_in -> sum nibble, carry_out); loop_over_all_nibbles holds the sequencer and registers.
REQ-028 Nibble index and last carry SHALL be internal signals visible hierarchically as curr_nibble_idx and result_carry.

Verification
REQ-029 ADD, word1=0xFF, word2=4, loop_nibbles_number=0, preinit_result=0xFF -> result=0x103:
  - with macro: busy high 3 cycles after request
  - without macro: busy high 8 cycles after request.
REQ-030 ADD, word1=0, word2=0x07B (123), loop_nibbles_number=2, word2_is_negative=0 -> result=0x0000007B.
REQ-031 ADD, word1=5, word2=0xFFE, loop_nibbles_number=2, word2_is_negative=1 -> result=3.
REQ-032 SUB, word1=10, word2=3, loop_nibbles_number=7 -> result=7; SUB, word1=0, word2=1 -> result=0xFFFFFFFF.
REQ-033 XOR, word1=0xF0F0F0F0, word2=0xFFFFFFFF, loop_nibbles_number=7 -> result=0x0F0F0F0F.
REQ-034 Handshake and reset:
  - loop_perm_to_count held high through DONE -> exactly one operation runs.
  - rst_n pulsed low mid-RUN -> result=0, busy=0, state IDLE.
